// File: rtl/compare_driver_pkg.sv
// Shared definitions for the compare driver: verdict codes, LFSR constants, FSM states.
// Used by compare_driver (optional checker enabled by CMP_DRIVER_CHECK_EN).
package compare_driver_pkg;

    localparam logic [2:0]  CMP_GT        = 3'b100;
    localparam logic [2:0]  CMP_EQ        = 3'b010;
    localparam logic [2:0]  CMP_LT        = 3'b001;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drv_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [2:0] cmp_ref(input logic [15:0] a, input logic [15:0] b);
        if (a > b)
            return CMP_GT;
        else if (a == b)
            return CMP_EQ;
        else
            return CMP_LT;
    endfunction

endpackage

// File: rtl/compare_driver_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step; next_state exposes the
// look-ahead value so the driver can issue two consecutive states per cycle.
module compare_driver_lfsr16
    import compare_driver_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    output logic [15:0] state,
    output logic [15:0] next_state
);

    always_ff @(posedge clk) begin
        if (reset)
            state <= LFSR_SEED_DEF;
        else if (load)
            state <= load_value;
        else if (step)
            state <= lfsr_next(state);
    end

    assign next_state = lfsr_next(state);

endmodule

// File: rtl/compare_driver.sv
// Operand-pair generator and verdict tally for the compare block.
// Define CMP_DRIVER_CHECK_EN to build the shadow-operand reference checker driving mismatch.
module compare_driver
    import compare_driver_pkg::*;
#(
    parameter int CMP_LAT  = 1,
    parameter int EQ_EVERY = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [7:0]  count,
    input  logic [2:0]  compare_var,
    output logic [15:0] number0,
    output logic [15:0] number1,
    output logic        busy,
    output logic        done,
    output logic [7:0]  gt_cnt,
    output logic [7:0]  eq_cnt,
    output logic [7:0]  lt_cnt,
    output logic        err,
    output logic        mismatch
);

    localparam logic [7:0]         EQ_MASK = 8'(EQ_EVERY - 1);
    localparam logic [CMP_LAT-1:0] VP_TOP  = CMP_LAT'(1) << (CMP_LAT - 1);

    drv_state_t         state;
    logic [7:0]         count_q;
    logic [7:0]         issued;
    logic               pair_valid;
    logic [CMP_LAT-1:0] vpipe;
    logic [15:0]        lfsr_state;
    logic [15:0]        lfsr_look;
    logic [15:0]        seed_eff;
    logic               start_load;
    logic               issue_more;
    logic               capture;
    logic               drain_empty;
    logic               eq_pair;

    assign seed_eff    = (seed == 16'h0000) ? LFSR_SEED_DEF : seed;
    assign start_load  = (state == IDLE) && start && (count != 8'd0);
    assign issue_more  = (state == ISSUE) && (issued != count_q);
    assign capture     = vpipe[CMP_LAT-1];
    assign eq_pair     = (issued & EQ_MASK) == EQ_MASK;
    // Empty once the tag now leaving the pipe is the only one still in flight.
    assign drain_empty = !pair_valid && ((vpipe & ~VP_TOP) == '0);

    // Pair 0 is issued straight from the seed, so the LFSR is loaded one step ahead.
    compare_driver_lfsr16 u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (start_load),
        .load_value (lfsr_next(seed_eff)),
        .step       (issue_more),
        .state      (lfsr_state),
        .next_state (lfsr_look)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count_q    <= 8'd0;
            issued     <= 8'd0;
            pair_valid <= 1'b0;
            vpipe      <= '0;
            number0    <= 16'h0000;
            number1    <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            gt_cnt     <= 8'd0;
            eq_cnt     <= 8'd0;
            lt_cnt     <= 8'd0;
            err        <= 1'b0;
        end else begin
            done       <= 1'b0;
            pair_valid <= start_load || issue_more;
            vpipe      <= (vpipe << 1) | CMP_LAT'(pair_valid);

            if (start_load) begin
                number0 <= seed_eff;
                number1 <= lfsr_next(seed_eff);
            end else if (issue_more) begin
                number0 <= lfsr_state;
                number1 <= eq_pair ? lfsr_state : lfsr_look;
                issued  <= issued + 8'd1;
            end

            if (capture) begin
                case (compare_var)
                    CMP_GT:  gt_cnt <= gt_cnt + 8'd1;
                    CMP_EQ:  eq_cnt <= eq_cnt + 8'd1;
                    CMP_LT:  lt_cnt <= lt_cnt + 8'd1;
                    default: err    <= 1'b1;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        count_q <= count;
                        issued  <= (count != 8'd0) ? 8'd1 : 8'd0;
                        gt_cnt  <= 8'd0;
                        eq_cnt  <= 8'd0;
                        lt_cnt  <= 8'd0;
                        err     <= 1'b0;
                        if (count == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!issue_more || (issued + 8'd1 == count_q))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMP_DRIVER_CHECK_EN
    logic [15:0] sh0 [CMP_LAT];
    logic [15:0] sh1 [CMP_LAT];
    logic [2:0]  ref_var;

    assign ref_var = cmp_ref(sh0[CMP_LAT-1], sh1[CMP_LAT-1]);

    // Shadow operands line up with the valid pipe so the reference matches the captured verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CMP_LAT; i++) begin
                sh0[i] <= 16'h0000;
                sh1[i] <= 16'h0000;
            end
            mismatch <= 1'b0;
        end else begin
            sh0[0] <= number0;
            sh1[0] <= number1;
            for (int i = 1; i < CMP_LAT; i++) begin
                sh0[i] <= sh0[i-1];
                sh1[i] <= sh1[i-1];
            end
            if ((state == IDLE) && start)
                mismatch <= 1'b0;
            else if (capture && (compare_var != ref_var))
                mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_compare_driver.sv
// Self-checking bench for compare_driver: a latency-1 compare stub with fault injection,
// a table of runs checked against an LFSR reference model, plus reset and restart sequences.
module tb_compare_driver;

    localparam int CMP_LAT  = 1;
    localparam int EQ_EVERY = 8;
`ifdef CMP_DRIVER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] seed;
        logic [7:0]  count;
        int          mode;
        int          bad_k;
        bit          restart;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic [7:0]  count = 8'd0;
    logic [2:0]  compare_var = 3'b000;
    logic [15:0] number0, number1;
    logic        busy, done, err, mismatch;
    logic [7:0]  gt_cnt, eq_cnt, lt_cnt;

    int          pass_cnt = 0;
    int          check_cnt = 0;
    int          stub_mode = 0;
    logic [15:0] inj_n0 = 16'h0000;
    logic [15:0] inj_n1 = 16'h0000;
    logic [15:0] last_n0 = 16'h0000;
    logic [15:0] last_n1 = 16'h0000;
    logic [31:0] pair_q [$];
    vec_t        vecs [8];

    compare_driver #(
        .CMP_LAT  (CMP_LAT),
        .EQ_EVERY (EQ_EVERY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seed        (seed),
        .count       (count),
        .compare_var (compare_var),
        .number0     (number0),
        .number1     (number1),
        .busy        (busy),
        .done        (done),
        .gt_cnt      (gt_cnt),
        .eq_cnt      (eq_cnt),
        .lt_cnt      (lt_cnt),
        .err         (err),
        .mismatch    (mismatch)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0])
            r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [2:0] true_verdict(input logic [15:0] a, input logic [15:0] b);
        if (a > b)
            return 3'b100;
        if (a == b)
            return 3'b010;
        return 3'b001;
    endfunction

    // Registered compare stub: one cycle from operands to verdict, with optional faults.
    always @(posedge clk) begin
        if (stub_mode == 1 && number0 == inj_n0 && number1 == inj_n1)
            compare_var <= 3'b011;
        else if (stub_mode == 2 && number0 == number1)
            compare_var <= 3'b100;
        else
            compare_var <= true_verdict(number0, number1);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] sd, input logic [7:0] cnt,
                                 input int mode, input int bad_k, input bit restart);
        logic [15:0] s, s1, n0, n1;
        logic [2:0]  tv, sv;
        logic [31:0] want;
        int          exp_gt, exp_eq, exp_lt, done_seen, done_at, exp_done_at;
        bit          exp_err, exp_mis;
        exp_gt = 0; exp_eq = 0; exp_lt = 0; done_seen = 0; done_at = 0;
        exp_err = 1'b0; exp_mis = 1'b0;
        s = (sd == 16'h0000) ? 16'hACE1 : sd;
        pair_q.delete();
        for (int k = 0; k < int'(cnt); k++) begin
            n0 = s;
            s1 = model_step(s);
            n1 = (k % EQ_EVERY == EQ_EVERY - 1) ? s : s1;
            s  = s1;
            pair_q.push_back({n0, n1});
            tv = true_verdict(n0, n1);
            if (mode == 1 && k == bad_k) begin
                sv = 3'b011;
                inj_n0 = n0;
                inj_n1 = n1;
            end else if (mode == 2 && n0 == n1)
                sv = 3'b100;
            else
                sv = tv;
            if (sv == 3'b100)      exp_gt++;
            else if (sv == 3'b010) exp_eq++;
            else if (sv == 3'b001) exp_lt++;
            else                   exp_err = 1'b1;
            if (CHECK_EN && sv != tv)
                exp_mis = 1'b1;
            last_n0 = n0;
            last_n1 = n1;
        end
        exp_done_at = (cnt == 8'd0) ? 1 : int'(cnt) + CMP_LAT + 1;

        @(negedge clk);
        stub_mode = mode;
        seed      = sd;
        count     = cnt;
        start     = 1'b1;
        for (int c = 1; c <= int'(cnt) + CMP_LAT + 6; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (restart && c == 3) begin
                start = 1'b1;
                count = 8'd0;
                seed  = 16'h0000;
            end
            if (done) begin
                done_seen++;
                if (done_at == 0)
                    done_at = c;
            end
            if (c == 1)
                checkOutput({tag, "_busy_first"}, busy, (cnt != 8'd0));
            if (pair_q.size() > 0) begin
                want = pair_q.pop_front();
                checkOutput($sformatf("%s_pair_c%0d", tag, c), {number0, number1}, want);
            end
        end
        checkOutput({tag, "_done_pulses"}, done_seen, 1);
        checkOutput({tag, "_done_cycle"}, done_at, exp_done_at);
        checkOutput({tag, "_gt_cnt"}, gt_cnt, exp_gt);
        checkOutput({tag, "_eq_cnt"}, eq_cnt, exp_eq);
        checkOutput({tag, "_lt_cnt"}, lt_cnt, exp_lt);
        checkOutput({tag, "_err"}, err, exp_err);
        checkOutput({tag, "_mismatch"}, mismatch, exp_mis);
        checkOutput({tag, "_hold_ops"}, {number0, number1}, {last_n0, last_n1});
        checkOutput({tag, "_busy_end"}, busy, 1'b0);
        stub_mode = 0;
    endtask

    initial begin
        int dseen;
        vecs[0] = '{16'h0001, 8'd1,   0, 0, 1'b0};
        vecs[1] = '{16'hACE1, 8'd16,  0, 0, 1'b0};
        vecs[2] = '{16'hBEEF, 8'd0,   0, 0, 1'b0};
        vecs[3] = '{16'h0000, 8'd9,   0, 0, 1'b0};
        vecs[4] = '{16'h1234, 8'd8,   1, 2, 1'b0};
        vecs[5] = '{16'hACE1, 8'd16,  2, 0, 1'b0};
        vecs[6] = '{16'h0F0F, 8'd10,  0, 0, 1'b1};
        vecs[7] = '{16'h5A5A, 8'd255, 0, 0, 1'b0};

        // Reset held for three cycles: everything quiet and zero.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_outputs",
                        {number0, number1, gt_cnt, eq_cnt, lt_cnt, busy, done, err, mismatch}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("v%0d", i), vecs[i].seed, vecs[i].count,
                          vecs[i].mode, vecs[i].bad_k, vecs[i].restart);
            if (i == 0) begin
                checkOutput("t2_number0", number0, 16'h0001);
                checkOutput("t2_number1", number1, 16'hB400);
                checkOutput("t2_lt_cnt", lt_cnt, 8'd1);
            end
            if (i == 1)
                checkOutput("t3_eq_at_least_2", (eq_cnt >= 8'd2), 1'b1);
        end

        // Reset in the middle of a long run: immediate return to idle, no done pulse.
        @(negedge clk);
        seed  = 16'h0005;
        count = 8'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checkOutput("t5_busy_mid", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_after_reset",
                    {number0, number1, gt_cnt, eq_cnt, lt_cnt, busy, done, err, mismatch}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dseen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done)
                dseen++;
        end
        checkOutput("t5_no_done", dseen, 0);
        last_n0 = 16'h0000;
        last_n1 = 16'h0000;
        applyStimulus("t5_fresh", 16'h0042, 8'd4, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
